// File: rtl/mem_arb_pkg.sv
// Shared encodings and widths for the two-master SRAM arbiter.
// Default address width is 8; override through the ADR_WIDTH parameter.
package mem_arb_pkg;

  localparam int MEMARB_ADR_WIDTH = 8;

  localparam int   MEMARB_WAIT_WIDTH = 4;
  localparam logic MEMARB_M_CPU      = 1'b0;
  localparam logic MEMARB_M_LDR      = 1'b1;

  typedef enum logic [3:0] {
    MEMARB_S_IDLE  = 4'b0001,
    MEMARB_S_ISSUE = 4'b0010,
    MEMARB_S_WAIT  = 4'b0100,
    MEMARB_S_DONE  = 4'b1000
  } memarb_state_e;

endpackage

// File: rtl/mem_arb_rr.sv
// Two-way round-robin picker: with both eligible, the master not served last wins.
// lock masks the CPU so only the loader can be picked.
module mem_arb_rr
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  input  logic       lock,
  output logic       any,
  output logic       win
);

  logic [1:0] elig;

  always_comb begin
    elig = lock ? {req[MEMARB_M_LDR], 1'b0} : req;
    any  = |elig;
    win  = (elig == 2'b11) ? ~last : elig[MEMARB_M_LDR];
  end

endmodule

// File: rtl/mem_arb.sv
// Two-master arbiter for the single-port SRAM: IDLE -> ISSUE -> WAIT -> DONE.
// Loader bus lock is built only when MEM_ARB_LOCK_EN is defined.
module mem_arb
  import mem_arb_pkg::*;
#(
  parameter int ADR_WIDTH   = MEMARB_ADR_WIDTH,
  parameter int DAT_WIDTH   = 8,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 m0_req_i,
  input  logic                 m0_we_i,
  input  logic [ADR_WIDTH-1:0] m0_adr_i,
  input  logic [DAT_WIDTH-1:0] m0_dat_i,
  output logic                 m0_gnt_o,
  output logic                 m0_ack_o,
  input  logic                 m1_req_i,
  input  logic                 m1_we_i,
  input  logic [ADR_WIDTH-1:0] m1_adr_i,
  input  logic [DAT_WIDTH-1:0] m1_dat_i,
  output logic                 m1_gnt_o,
  output logic                 m1_ack_o,
`ifdef MEM_ARB_LOCK_EN
  input  logic                 m1_lock_i,
`endif
  output logic [DAT_WIDTH-1:0] dat_o,
  output logic                 mem_en_o,
  output logic                 mem_we_o,
  output logic [ADR_WIDTH-1:0] mem_adr_o,
  output logic [DAT_WIDTH-1:0] mem_dat_o,
  input  logic [DAT_WIDTH-1:0] mem_dat_i
);

  localparam logic [MEMARB_WAIT_WIDTH-1:0] WAIT_LOAD =
    MEMARB_WAIT_WIDTH'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  memarb_state_e                state;
  logic                         owner;
  logic                         rr_last;
  logic                         lock_act;
  logic                         pick_any;
  logic                         pick_win;
  logic [MEMARB_WAIT_WIDTH-1:0] wait_cnt;
  logic [1:0]                   gnt_q;
  logic [1:0]                   ack_q;

  // Lock only holds the bus for a loader that already owns it.
`ifdef MEM_ARB_LOCK_EN
  assign lock_act = m1_lock_i && (owner == MEMARB_M_LDR);
`else
  assign lock_act = 1'b0;
`endif

  mem_arb_rr u_rr (
    .req  ({m1_req_i, m0_req_i}),
    .last (rr_last),
    .lock (lock_act),
    .any  (pick_any),
    .win  (pick_win)
  );

  assign m0_gnt_o = gnt_q[MEMARB_M_CPU];
  assign m1_gnt_o = gnt_q[MEMARB_M_LDR];
  assign m0_ack_o = ack_q[MEMARB_M_CPU];
  assign m1_ack_o = ack_q[MEMARB_M_LDR];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= MEMARB_S_IDLE;
      owner     <= MEMARB_M_CPU;
      rr_last   <= MEMARB_M_LDR;
      wait_cnt  <= '0;
      dat_o     <= '0;
      gnt_q     <= '0;
      ack_q     <= '0;
      mem_en_o  <= 1'b0;
      mem_we_o  <= 1'b0;
      mem_adr_o <= '0;
      mem_dat_o <= '0;
    end else begin
      case (state)
        MEMARB_S_IDLE: begin
          if (pick_any) begin
            state           <= MEMARB_S_ISSUE;
            owner           <= pick_win;
            gnt_q[pick_win] <= 1'b1;
            mem_en_o        <= 1'b1;
            mem_we_o        <= pick_win ? m1_we_i  : m0_we_i;
            mem_adr_o       <= pick_win ? m1_adr_i : m0_adr_i;
            mem_dat_o       <= pick_win ? m1_dat_i : m0_dat_i;
            if (!lock_act)
              rr_last <= pick_win;
          end
        end
        MEMARB_S_ISSUE: begin
          mem_en_o <= 1'b0;
          mem_we_o <= 1'b0;
          if (WAIT_CYCLES == 0) begin
            dat_o        <= mem_dat_i;
            ack_q[owner] <= 1'b1;
            state        <= MEMARB_S_DONE;
          end else begin
            wait_cnt <= WAIT_LOAD;
            state    <= MEMARB_S_WAIT;
          end
        end
        MEMARB_S_WAIT: begin
          if (wait_cnt == '0) begin
            dat_o        <= mem_dat_i;
            ack_q[owner] <= 1'b1;
            state        <= MEMARB_S_DONE;
          end else begin
            wait_cnt <= wait_cnt - MEMARB_WAIT_WIDTH'(1);
          end
        end
        MEMARB_S_DONE: begin
          gnt_q <= '0;
          ack_q <= '0;
          state <= MEMARB_S_IDLE;
        end
        default: state <= MEMARB_S_IDLE;
      endcase
    end
  end

endmodule
